// File: rtl/div_pkg.sv
// Shared types and widths for the iterative RV32M divider.
package div_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Shift {rem,quo} left, trial-subtract, restore on a negative difference.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider for EX; raises busy while a divide occupies EX.
module div_unit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            kill,
  output logic            busy,
  output logic [XLEN-1:0] rslt,
  output logic            rsltvld
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic            rem_sel_q;
  logic            sgn_a_q, sgn_b_q, special_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  div_op_e         op_e;
  logic            is_signed_c, sgn_a_c, sgn_b_c, div_zero_c, ovf_c, accept_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c, quo_fix_c, rem_fix_c;

  // Operand decode for the issue cycle.
  always_comb begin
    op_e        = div_op_e'(op);
    is_signed_c = (op_e == DIV) || (op_e == REM);
    sgn_a_c     = is_signed_c & srca[XLEN-1];
    sgn_b_c     = is_signed_c & srcb[XLEN-1];
    abs_a_c     = sgn_a_c ? (~srca + XLEN'(1)) : srca;
    abs_b_c     = sgn_b_c ? (~srcb + XLEN'(1)) : srcb;
    div_zero_c  = (srcb == '0);
    ovf_c       = is_signed_c && (srca == INT_MIN) && (srcb == '1);
    accept_c    = (state_q == IDLE) && start && !kill;
  end

  div_step u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and stall request; kill overrides every transition.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          busy    = 1'b1;
          state_d = (div_zero_c || ovf_c) ? DONE : BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q == CNTW'(XLEN - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Operand capture on issue, one restoring step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      sgn_a_q   <= 1'b0;
      sgn_b_q   <= 1'b0;
      special_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
    end else if (accept_c) begin
      cnt_q     <= '0;
      rem_sel_q <= op[1];
      sgn_a_q   <= sgn_a_c;
      sgn_b_q   <= sgn_b_c;
      dvsr_q    <= abs_b_c;
      special_q <= div_zero_c | ovf_c;
      if (div_zero_c) begin
        quo_q <= '1;
        rem_q <= srca;
      end else if (ovf_c) begin
        quo_q <= INT_MIN;
        rem_q <= '0;
      end else begin
        quo_q <= abs_a_c;
        rem_q <= '0;
      end
    end else if (state_q == BUSY) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // Result select with signed fix-up, presented only in the DONE cycle.
  always_comb begin
    quo_fix_c = (!special_q && (sgn_a_q ^ sgn_b_q)) ? (~quo_q + XLEN'(1)) : quo_q;
    rem_fix_c = (!special_q && sgn_a_q) ? (~rem_q + XLEN'(1)) : rem_q;
    rsltvld   = (state_q == DONE) && !kill;
    rslt      = '0;
    if (rsltvld) rslt = rem_sel_q ? rem_fix_c : quo_fix_c;
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit against an arithmetic reference.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic [31:0] rslt;
  logic        rsltvld;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .kill    (kill),
    .busy    (busy),
    .rslt    (rslt),
    .rsltvld (rsltvld)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!o[0]) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int exp_busy(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one divide, count busy cycles, verify rsltvld lands on the first non-busy cycle.
  task automatic run_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int bc;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    exp_q.push_back(ref_model(o, a, b));
    bc = 0;
    #2;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
      start = 1'b0;
      srca  = $urandom;
      srcb  = $urandom;
      #2;
    end
    check("busy_cycles", 32'(bc), 32'(exp_busy(o, a, b)));
    check("rsltvld_after_busy", {31'd0, rsltvld}, 32'd1);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rsltvld) begin
        check("busy_low_on_result", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rslt", rslt, e);
        end
      end
    end
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int bc;

    // Reset state
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rsltvld", {31'd0, rsltvld}, 32'd0);
    check("reset_rslt", rslt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_div(2'b00, 32'd100, 32'd7);
    run_div(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_div(2'b00, 32'hFFFF_FFF9, 32'd2);
    run_div(2'b01, 32'hFFFF_FFF9, 32'd2);
    run_div(2'b01, 32'd5, 32'd0);
    run_div(2'b11, 32'd5, 32'd0);
    run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(2'b00, 32'hFFFF_FFF9, 32'd0);
    run_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(2'b10, 32'd7, 32'hFFFF_FFFE);

    // kill together with start in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; op = 2'b01; srca = 32'd50; srcb = 32'd5; kill = 1'b1;
    #2;
    check("kill_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    #2;
    check("kill_idle_next_busy", {31'd0, busy}, 32'd0);

    // kill on the 10th busy cycle
    @(negedge clk);
    start = 1'b1; op = 2'b01; srca = 32'd1000; srcb = 32'd3;
    bc = 0;
    #2;
    while (busy && bc < 10) begin
      bc++;
      if (bc == 10) break;
      @(negedge clk);
      start = 1'b0;
      #2;
    end
    check("kill_reached_10", 32'(bc), 32'd10);
    kill = 1'b1;
    #1;
    check("kill_cycle_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    kill = 1'b0;
    #2;
    check("after_kill_busy", {31'd0, busy}, 32'd0);
    check("after_kill_rsltvld", {31'd0, rsltvld}, 32'd0);
    run_div(2'b01, 32'd9, 32'd3);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'(-$urandom_range(1, 15));
        3:       rb = $urandom >> $urandom_range(0, 31);
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(1, 31);
      run_div(ro, ra, rb);
    end

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    start = 1'b1; op = 2'b00; srca = 32'd12345; srcb = 32'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_rsltvld", {31'd0, rsltvld}, 32'd0);
    check("async_rst_rslt", rslt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (i % 10 == 0) begin
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_rsltvld", {31'd0, rsltvld}, 32'd0);
        check("post_rst_rslt", rslt, 32'd0);
      end
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider in the execute stage. It is the producer of the `busy` stall request consumed by the hazard unit.
- While a DIV/DIVU/REM/REMU occupies EX, `busy` holds the front end and EX. Execute is not flushed while `busy` is high.
- The result is presented in the single cycle the instruction leaves EX.
- Radix-2 restoring algorithm, one quotient bit per cycle, with early-out for the architectural special cases.

Parameters:
- XLEN, 32, operand/result width.
- CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  valid divide instruction in EX (level; sampled only in IDLE).
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- srca  in  XLEN  dividend (post-forwarding EX operand A).
- srcb  in  XLEN  divisor (post-forwarding EX operand B).
- kill  in  1  abort (trap/flush of EX); highest priority.
- busy  out  1  stall request to hazard unit.
- rslt  out  XLEN  quotient or remainder, valid only when rsltvld=1.
- rsltvld  out  1  result valid this cycle; EX advances on the following edge.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, rst_n=0): state=IDLE, counter=0, internal quotient/remainder/operand regs=0. Outputs: busy=0, rslt=0, rsltvld=0.
- busy is combinational: 1 when (state==IDLE && start && !kill) or state==BUSY; else 0. It is asserted in the same cycle start first rises, so F/D/E hold on that edge.
- IDLE & start & !kill, on the clock edge:
  - Latch op.
  - Latch sign flags: signed ops only; sign = MSB of each operand.
  - Latch |srca| and |srcb|. Unsigned ops use raw values.
  - Clear remainder; counter=0.
  - Operands are captured at this edge; later changes on srca/srcb are ignored.
- Special cases detected in IDLE. Next state is DONE (busy high 1 cycle):
  - Divisor==0: quotient = all ones; remainder = srca (all ops).
  - Signed overflow (op 00/10, srca=0x80000000, srcb=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
  - Otherwise next state is BUSY.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract divisor from rem (XLEN+1 bits).
  - If non-negative: keep the difference and set quo[0]=1.
  - counter++. After the XLEN-th step (counter==XLEN-1 at the edge), go to DONE.
  - busy is high for exactly XLEN+1 = 33 cycles, counting the start cycle.
- DONE: busy=0, rsltvld=1 for exactly one cycle.
  - rslt = quotient (op[1]=0) or remainder (op[1]=1).
  - Signed fix-up: quotient negated if the dividend and divisor signs differ; remainder takes the sign of the dividend. Fix-up does not apply to the special-case values.
  - Unconditionally return to IDLE on the next edge. The core must let EX advance, since busy=0.
- Back-to-back divides: start seen in the IDLE cycle after DONE begins a new operation. No bubble is needed beyond the DONE cycle.
- kill in any state: next state IDLE; no rsltvld pulse; busy is forced 0 combinationally in the kill cycle when in IDLE. In BUSY, busy stays 1 during the kill cycle and is 0 the cycle after.
- start ignored in BUSY/DONE.
- Width rules: all arithmetic is XLEN-bit two's complement. The absolute value of 0x80000000 is 0x80000000 treated as unsigned.

Decomposition:
- Shared package div_pkg:
  - div_op_e enum (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11).
  - div_state_e enum (IDLE, BUSY, DONE).
  - XLEN localparam.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Exists so the datapath can later be unrolled to radix-4 by instantiating it twice.

Test Plan:
- DIV 100/7 at start → busy=1 for 33 consecutive cycles; then rsltvld=1 one cycle with rslt=14; busy=0 on that cycle.
- REM -7/2 (0xFFFFFFF9, 2) → rslt=0xFFFFFFFF (-1). DIV same operands → 0xFFFFFFFD (-3). DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU 5/0 → busy high 1 cycle, next cycle rslt=0xFFFFFFFF. REMU 5/0 → rslt=5.
- DIV 0x80000000/0xFFFFFFFF → rslt=0x80000000 after 1 busy cycle. REM same → rslt=0.
- kill asserted on 10th busy cycle → busy=0 from the next cycle; no rsltvld. A subsequent DIVU 9/3 completes normally with rslt=3.
- rst_n pulled low asynchronously mid-BUSY (no clock edge) → busy, rsltvld, rslt go 0 immediately. After release with start=0, outputs stay 0.
